u_32b_add_2: RTL and testbench

- Unsigned 32-bit adder with carry-in, pipelined into two registered stages.
- Stage 1 adds the low half; stage 2 adds the high half using the registered low-half carry.
- Full throughput: one new operand pair accepted every clock.
- Used as the registered arithmetic add primitive in datapaths that need a short critical path.

---
 rtl/u_32b_add_2.sv | 89 ++++++++
 tb/tb_u_32b_add_2.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/u_32b_add_2.sv
// u_32b_add_2: unsigned WIDTH-bit adder with carry-in, split into two registered stages.
//   Stage 1 ripple-adds the low half and registers the low sum, the low carry, both operand
//   upper halves and in_valid. Stage 2 ripple-adds the upper halves with the registered
//   low carry and registers the full sum, the carry-out and the valid flag.
//   Latency is 2 clock edges with full throughput. Data registers load every cycle, and
//   out_valid is in_valid delayed by two stages.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; clears every pipeline register
//   in_valid  in1/in2/cin valid this cycle
//   in1, in2  unsigned operands (WIDTH bits)
//   cin       carry-in
//   sout      registered sum, (in1 + in2 + cin) mod 2^WIDTH
//   cout      registered carry-out (bit WIDTH of the full sum)
//   out_valid sout/cout hold a valid result
module u_32b_add_2 #(
  parameter int unsigned WIDTH = 32  // must be even; the stages split at WIDTH/2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] sout,
  output logic             cout,
  output logic             out_valid
);

  localparam int unsigned Half = WIDTH / 2;

  // Stage 1: low-half ripple chain fed directly from the inputs.
  logic [Half:0]   lo_c;
  logic [Half-1:0] lo_s;

  assign lo_c[0] = cin;

  for (genvar i = 0; i < Half; i++) begin : g_lo_fa
    assign lo_s[i]   = in1[i] ^ in2[i] ^ lo_c[i];
    assign lo_c[i+1] = (in1[i] & in2[i]) | (lo_c[i] & (in1[i] ^ in2[i]));
  end

  logic [Half-1:0] lo_sum_q;
  logic            lo_carry_q;
  logic [Half-1:0] a_hi_q;
  logic [Half-1:0] b_hi_q;
  logic            valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum_q   <= '0;
      lo_carry_q <= 1'b0;
      a_hi_q     <= '0;
      b_hi_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      lo_sum_q   <= lo_s;
      lo_carry_q <= lo_c[Half];
      a_hi_q     <= in1[WIDTH-1:Half];
      b_hi_q     <= in2[WIDTH-1:Half];
      valid_q    <= in_valid;
    end
  end

  // Stage 2: the high-half ripple chain starts from the registered low carry. This makes the
  // result identical to a single-cycle WIDTH-bit add.
  logic [Half:0]   hi_c;
  logic [Half-1:0] hi_s;

  assign hi_c[0] = lo_carry_q;

  for (genvar i = 0; i < Half; i++) begin : g_hi_fa
    assign hi_s[i]   = a_hi_q[i] ^ b_hi_q[i] ^ hi_c[i];
    assign hi_c[i+1] = (a_hi_q[i] & b_hi_q[i]) | (hi_c[i] & (a_hi_q[i] ^ b_hi_q[i]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout      <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sout      <= {hi_s, lo_sum_q};
      cout      <= hi_c[Half];
      out_valid <= valid_q;
    end
  end

endmodule

// File: tb/tb_u_32b_add_2.sv
// tb_u_32b_add_2: directed self-checking bench for u_32b_add_2 (WIDTH = 32).
//   Inputs are driven 1 time unit after a rising edge and captured on the next edge. The
//   result of the input captured at edge k appears after edge k+1, so each check follows
//   the tick that is one step after the matching drive.
module tb_u_32b_add_2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        cin;
  logic [31:0] sout;
  logic        cout;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  u_32b_add_2 #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in1      (in1),
    .in2      (in2),
    .cin      (cin),
    .sout     (sout),
    .cout     (cout),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic v);
    in1      = a;
    in2      = b;
    cin      = c;
    in_valid = v;
  endtask

  // Compare {out_valid, cout, sout} against the expected triple.
  task automatic check(input string tag, input logic [31:0] es, input logic ec,
                       input logic ev);
    logic [33:0] obs;
    logic [33:0] exp;
    obs = {out_valid, cout, sout};
    exp = {ev, ec, es};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed v=%b c=%b s=%h expected v=%b c=%b s=%h",
             tag, obs[33], obs[32], obs[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Reference: {valid, 33-bit sum}.
  function automatic logic [33:0] model(input logic v, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + {32'd0, c};
    return {v, s};
  endfunction

  logic [33:0] prev_exp;
  logic [33:0] cur_exp;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rc;
  logic        rv;

  initial begin
    // Reset held with nonzero inputs.
    rst_n = 1'b0;
    drive(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
    #2;
    check("reset_async", 32'h0, 1'b0, 1'b0);
    tick();
    check("reset_hold", 32'h0, 1'b0, 1'b0);

    // Release mid-cycle and stream back-to-back vectors.
    rst_n = 1'b1;
    drive(32'd1000, 32'd1010, 1'b0, 1'b1);
    tick();
    check("post_reset_first_edge", 32'h0, 1'b0, 1'b0);
    drive(32'd1000000, 32'd1000010, 1'b0, 1'b1);
    tick();
    check("add_1000_1010", 32'd2010, 1'b0, 1'b1);
    drive(32'd25, 32'd6, 1'b0, 1'b1);
    tick();
    check("add_1e6", 32'd2000010, 1'b0, 1'b1);
    drive(32'd55, 32'd5, 1'b0, 1'b1);
    tick();
    check("add_25_6", 32'd31, 1'b0, 1'b1);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick();
    check("add_55_5", 32'd60, 1'b0, 1'b1);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    tick();
    check("ovf_cin0", 32'hFFFF_FFFE, 1'b1, 1'b1);
    drive(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    tick();
    check("ovf_cin1_max", 32'hFFFF_FFFF, 1'b1, 1'b1);
    drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    tick();
    check("split_carry", 32'h0001_0000, 1'b0, 1'b1);

    // Valid gap pattern 1,0,1,1.
    drive(32'd7, 32'd8, 1'b0, 1'b1);
    tick();
    check("ripple_both_stages", 32'h0, 1'b1, 1'b1);
    drive(32'd3, 32'd4, 1'b1, 1'b0);
    tick();
    check("gap_v1", 32'd15, 1'b0, 1'b1);
    drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    tick();
    check("gap_v0", 32'd8, 1'b0, 1'b0);
    drive(32'hFFFF_0000, 32'h0001_0000, 1'b1, 1'b1);
    tick();
    check("gap_v1b", 32'h0, 1'b1, 1'b1);

    // Inputs held with in_valid low: data holds, only out_valid drops.
    in_valid = 1'b0;
    tick();
    check("gap_v1c", 32'h1, 1'b1, 1'b1);
    tick();
    check("hold_1", 32'h1, 1'b1, 1'b0);
    tick();
    check("hold_2", 32'h1, 1'b1, 1'b0);

    // Reset in the middle of traffic discards in-flight results.
    drive(32'd100, 32'd200, 1'b0, 1'b1);
    tick();
    check("hold_3", 32'h1, 1'b1, 1'b0);
    drive(32'd5, 32'd5, 1'b0, 1'b1);
    tick();
    check("pre_mid_reset", 32'd300, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", 32'h0, 1'b0, 1'b0);
    tick();
    check("mid_reset_hold", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(32'd9, 32'd9, 1'b0, 1'b1);
    tick();
    check("mid_reset_no_partial", 32'h0, 1'b0, 1'b0);
    tick();
    check("mid_reset_recover", 32'd18, 1'b0, 1'b1);

    // Random traffic against the reference model.
    ra = $urandom();
    rb = $urandom();
    rc = 1'($urandom_range(1));
    rv = 1'($urandom_range(1));
    drive(ra, rb, rc, rv);
    tick();
    prev_exp = model(rv, ra, rb, rc);
    for (int i = 0; i < 500; i++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(1));
      rv = 1'($urandom_range(1));
      // Bias some operands toward the low-half carry boundary.
      if (i % 7 == 0) ra[15:0] = 16'hFFFF;
      drive(ra, rb, rc, rv);
      tick();
      check("random", prev_exp[31:0], prev_exp[32], prev_exp[33]);
      cur_exp  = model(rv, ra, rb, rc);
      prev_exp = cur_exp;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
